// File: rtl/sc_statemachine_race.sv
// -----------------------------------------------------------------------------
// sc_statemachine_race
//   Game controller for the N-player car race. Sequences start, ready,
//   per-level move cycles, collision loss and win. Owns the score counter,
//   the level index, the latched loser mask and the end-of-game hold counter.
//   Drives the timer reload value and the one-cycle move strobe that steps the
//   car shift registers in the datapath.
// -----------------------------------------------------------------------------
module sc_statemachine_race #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_LEVELS  = 3,
  parameter int POINT_W     = 8,
  parameter int LEVEL_STEP  = 32,
  parameter int WIN_POINTS  = 128,
  parameter int TIMER_W     = 4,
  parameter int BASE_PERIOD = 12,
  parameter int PERIOD_STEP = 4,
  parameter int HOLD_TICKS  = 3,
  // Derived widths; a single-level game still gets a 1-bit level bus.
  localparam int LEVEL_W    = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                   SC_STATEMACHINE_RACE_CLOCK_50,
  input  logic                   SC_STATEMACHINE_RACE_RESET_InLow,
  input  logic                   SC_STATEMACHINE_RACE_startButton_InLow,
  input  logic [NUM_PLAYERS-1:0] SC_STATEMACHINE_RACE_ready_InLow,
  input  logic                   SC_STATEMACHINE_RACE_timer_InLow,
  input  logic [NUM_PLAYERS-1:0] SC_STATEMACHINE_RACE_collision_InLow,
  output logic                   SC_STATEMACHINE_RACE_clear_OutLow,
  output logic                   SC_STATEMACHINE_RACE_move_Out,
  output logic [TIMER_W-1:0]     SC_STATEMACHINE_RACE_timerLoad_OutBUS,
  output logic [LEVEL_W-1:0]     SC_STATEMACHINE_RACE_level_OutBUS,
  output logic [POINT_W-1:0]     SC_STATEMACHINE_RACE_points_OutBUS,
  output logic [NUM_PLAYERS-1:0] SC_STATEMACHINE_RACE_loser_OutBUS,
  output logic                   SC_STATEMACHINE_RACE_win_Out
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  // Four-bit encoding leaves spare codes; any of them recovers through RESET.
  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_START = 4'd1,
    ST_GO    = 4'd2,
    ST_PLAY  = 4'd3,
    ST_MOVE  = 4'd4,
    ST_CHECK = 4'd5,
    ST_LOSE  = 4'd6,
    ST_WIN   = 4'd7
  } state_e;

  // Short local names for the clock, reset and the active-low inputs.
  logic                   clk;
  logic                   rst_n;
  logic                   start_req;
  logic                   all_ready;
  logic                   timer_exp;
  logic                   any_hit;

  assign clk       = SC_STATEMACHINE_RACE_CLOCK_50;
  assign rst_n     = SC_STATEMACHINE_RACE_RESET_InLow;
  assign start_req = ~SC_STATEMACHINE_RACE_startButton_InLow;
  assign all_ready = (SC_STATEMACHINE_RACE_ready_InLow == '0);
  assign timer_exp = ~SC_STATEMACHINE_RACE_timer_InLow;
  assign any_hit   = (SC_STATEMACHINE_RACE_collision_InLow != '1);

  state_e                 state_q,  state_d;
  logic [POINT_W-1:0]     points_q, points_d;
  logic [LEVEL_W-1:0]     level_q,  level_d;
  logic [NUM_PLAYERS-1:0] loser_q,  loser_d;
  logic [HOLD_W-1:0]      hold_q,   hold_d;

  logic [POINT_W-1:0]     points_inc;
  logic [LEVEL_W-1:0]     level_target;
  int                     level_calc;
  int                     reload_calc;

  // Saturating score increment: the counter parks at all-ones.
  assign points_inc = (points_q == '1) ? points_q : points_q + 1'b1;

  // Level the current score entitles the player to, capped at the top level
  // and never below the level already reached.
  always_comb begin
    level_calc = int'(points_q) / LEVEL_STEP;
    if (level_calc > NUM_LEVELS - 1) begin
      level_calc = NUM_LEVELS - 1;
    end
    if (level_calc < int'(level_q)) begin
      level_calc = int'(level_q);
    end
    level_target = LEVEL_W'(level_calc);
  end

  // Timer reload shrinks with each level and bottoms out at one tick.
  always_comb begin
    // NOTE: signed int arithmetic so an over-large level goes negative and
    // clamps, instead of wrapping to a huge unsigned reload.
    reload_calc = BASE_PERIOD - int'(level_q) * PERIOD_STEP;
    if (reload_calc < 1) begin
      reload_calc = 1;
    end
  end

  // Next-state and next-register logic for the game sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    state_d  = state_q;
    points_d = points_q;
    level_d  = level_q;
    loser_d  = loser_q;
    hold_d   = hold_q;

    unique case (state_q)
      ST_RESET: state_d = ST_START;

      ST_START: if (start_req) state_d = ST_GO;

      ST_GO: if (all_ready) state_d = ST_PLAY;

      ST_PLAY: if (timer_exp) state_d = ST_MOVE;

      ST_MOVE: begin
        points_d = points_inc;
        state_d  = ST_CHECK;
      end

      // Collision beats win; a clean move may promote the level.
      ST_CHECK: begin
        if (any_hit) begin
          loser_d = ~SC_STATEMACHINE_RACE_collision_InLow;
          state_d = ST_LOSE;
        end else if (points_q >= POINT_W'(WIN_POINTS)) begin
          state_d = ST_WIN;
        end else begin
          level_d = level_target;
          state_d = ST_PLAY;
        end
      end

      // Hold the result on screen for a number of timer expiries.
      ST_LOSE, ST_WIN: begin
        if (timer_exp) begin
          if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
            state_d = ST_RESET;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end

      default: state_d = ST_RESET;
    endcase

    // Every way into RESET wipes the game registers on the same edge.
    if (state_d == ST_RESET) begin
      points_d = '0;
      level_d  = '0;
      loser_d  = '0;
      hold_d   = '0;
    end
  end

  // State and game registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q  <= ST_RESET;
      points_q <= '0;
      level_q  <= '0;
      loser_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      points_q <= points_d;
      level_q  <= level_d;
      loser_q  <= loser_d;
      hold_q   <= hold_d;
    end
  end

  // Outputs are decodes of registered state, valid in the cycle a state is entered.
  assign SC_STATEMACHINE_RACE_clear_OutLow     = (state_q != ST_RESET);
  assign SC_STATEMACHINE_RACE_move_Out         = (state_q == ST_MOVE);
  assign SC_STATEMACHINE_RACE_win_Out          = (state_q == ST_WIN);
  assign SC_STATEMACHINE_RACE_timerLoad_OutBUS = TIMER_W'(reload_calc);
  assign SC_STATEMACHINE_RACE_level_OutBUS     = level_q;
  assign SC_STATEMACHINE_RACE_points_OutBUS    = points_q;
  assign SC_STATEMACHINE_RACE_loser_OutBUS     = loser_q;

endmodule

// File: tb/tb_sc_statemachine_race.sv
// -----------------------------------------------------------------------------
// tb_sc_statemachine_race
//   Self-checking bench for the race controller. A 2-player default instance
//   runs a full game to win, loss, draw and a reset mid-move; a scoreboard
//   holds the score expected after each move strobe. A 4-player, 5-level
//   instance covers the wide ready bus and reload saturation.
// -----------------------------------------------------------------------------
module tb_sc_statemachine_race;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-player instance
  logic       rst_n, start_n, timer_n;
  logic [1:0] ready, coll;
  logic       clear, move, win;
  logic [3:0] tload;
  logic [1:0] level;
  logic [7:0] points;
  logic [1:0] loser;

  sc_statemachine_race dut (
    .SC_STATEMACHINE_RACE_CLOCK_50          (clk),
    .SC_STATEMACHINE_RACE_RESET_InLow       (rst_n),
    .SC_STATEMACHINE_RACE_startButton_InLow (start_n),
    .SC_STATEMACHINE_RACE_ready_InLow       (ready),
    .SC_STATEMACHINE_RACE_timer_InLow       (timer_n),
    .SC_STATEMACHINE_RACE_collision_InLow   (coll),
    .SC_STATEMACHINE_RACE_clear_OutLow      (clear),
    .SC_STATEMACHINE_RACE_move_Out          (move),
    .SC_STATEMACHINE_RACE_timerLoad_OutBUS  (tload),
    .SC_STATEMACHINE_RACE_level_OutBUS      (level),
    .SC_STATEMACHINE_RACE_points_OutBUS     (points),
    .SC_STATEMACHINE_RACE_loser_OutBUS      (loser),
    .SC_STATEMACHINE_RACE_win_Out           (win)
  );

  // 4-player, 5-level instance; win threshold raised so level 4 is reachable
  logic       rst4_n, start4_n, timer4_n;
  logic [3:0] ready4, coll4;
  logic       clear4, move4, win4;
  logic [3:0] tload4;
  logic [2:0] level4;
  logic [7:0] points4;
  logic [3:0] loser4;

  sc_statemachine_race #(
    .NUM_PLAYERS(4), .NUM_LEVELS(5), .PERIOD_STEP(4), .WIN_POINTS(200)
  ) dut4 (
    .SC_STATEMACHINE_RACE_CLOCK_50          (clk),
    .SC_STATEMACHINE_RACE_RESET_InLow       (rst4_n),
    .SC_STATEMACHINE_RACE_startButton_InLow (start4_n),
    .SC_STATEMACHINE_RACE_ready_InLow       (ready4),
    .SC_STATEMACHINE_RACE_timer_InLow       (timer4_n),
    .SC_STATEMACHINE_RACE_collision_InLow   (coll4),
    .SC_STATEMACHINE_RACE_clear_OutLow      (clear4),
    .SC_STATEMACHINE_RACE_move_Out          (move4),
    .SC_STATEMACHINE_RACE_timerLoad_OutBUS  (tload4),
    .SC_STATEMACHINE_RACE_level_OutBUS      (level4),
    .SC_STATEMACHINE_RACE_points_OutBUS     (points4),
    .SC_STATEMACHINE_RACE_loser_OutBUS      (loser4),
    .SC_STATEMACHINE_RACE_win_Out           (win4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: score expected in the cycle after each move strobe.
  logic [7:0] sb[$];
  logic       pend = 1'b0;

  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() > 0) check("pts_after_move", 32'(points), 32'(sb.pop_front()));
      else               check("sb_underflow", 32'(sb.size()), 32'd1);
    end
    if (move) check("move_expected", 32'(sb.size() > 0), 32'd1);
    pend <= move;
  end

  // One full PLAY -> MOVE -> CHECK -> next-state round on the 2-player DUT.
  task automatic move_once(input logic [7:0] exp_pts);
    sb.push_back(exp_pts);
    timer_n = 1'b0;
    tick();
    timer_n = 1'b1;
    tick();
    tick();
  endtask

  // One timer expiry pulse, used while holding in LOSE/WIN.
  task automatic hold_pulse();
    timer_n = 1'b0;
    tick();
    timer_n = 1'b1;
    tick();
  endtask

  // START -> GO -> PLAY on the 2-player DUT.
  task automatic start_game();
    start_n = 1'b0;
    tick();
    start_n = 1'b1;
    ready   = 2'b00;
    tick();
    ready   = 2'b11;
  endtask

  task automatic move4_once();
    timer4_n = 1'b0;
    tick();
    timer4_n = 1'b1;
    tick();
    tick();
  endtask

  // Hard stop in case anything stalls the run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_load4 [4];
    exp_load4[0] = 4'd8; exp_load4[1] = 4'd4; exp_load4[2] = 4'd1; exp_load4[3] = 4'd1;

    rst_n  = 1'b0; start_n  = 1'b1; ready  = 2'b11; timer_n  = 1'b1; coll  = 2'b11;
    rst4_n = 1'b0; start4_n = 1'b1; ready4 = 4'hF;  timer4_n = 1'b1; coll4 = 4'hF;

    // ---- reset and START
    tick(); tick();
    @(negedge clk);
    check("rst_clear", 32'(clear), 0);
    check("rst_points", 32'(points), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_clear_low", 32'(clear), 0);
    tick();
    @(negedge clk);
    check("start_clear", 32'(clear), 1);
    check("start_move", 32'(move), 0);
    check("start_win", 32'(win), 0);
    check("start_points", 32'(points), 0);
    check("start_level", 32'(level), 0);
    check("start_loser", 32'(loser), 0);
    check("start_tload", 32'(tload), 12);

    // ---- GO waits for every ready bit; timer ignored in GO
    start_n = 1'b0;
    tick();
    start_n = 1'b1;
    ready   = 2'b10;
    tick(); tick();
    timer_n = 1'b0;
    tick();
    timer_n = 1'b1;
    tick();
    @(negedge clk);
    check("go_no_move", 32'(move), 0);
    check("go_points", 32'(points), 0);
    ready = 2'b00;
    tick();
    ready = 2'b11;

    // ---- first move: timer held low through MOVE and CHECK, one move only
    sb.push_back(8'd1);
    timer_n = 1'b0;
    tick();
    @(negedge clk);
    check("move_pulse", 32'(move), 1);
    tick();
    @(negedge clk);
    check("move_one_cycle", 32'(move), 0);
    tick();
    timer_n = 1'b1;
    tick();
    @(negedge clk);
    check("no_queued_move", 32'(move), 0);
    check("points_1", 32'(points), 1);

    // ---- level progression
    for (int p = 2; p <= 31; p++) move_once(8'(p));
    @(negedge clk);
    check("lvl_at_31", 32'(level), 0);
    check("tload_at_31", 32'(tload), 12);
    move_once(8'd32);
    @(negedge clk);
    check("lvl_at_32", 32'(level), 1);
    check("tload_at_32", 32'(tload), 8);
    for (int p = 33; p <= 64; p++) move_once(8'(p));
    @(negedge clk);
    check("lvl_at_64", 32'(level), 2);
    check("tload_at_64", 32'(tload), 4);
    for (int p = 65; p <= 127; p++) move_once(8'(p));
    @(negedge clk);
    check("lvl_cap_127", 32'(level), 2);
    check("win_at_127", 32'(win), 0);
    move_once(8'd128);
    @(negedge clk);
    check("win_at_128", 32'(win), 1);
    check("points_128", 32'(points), 128);

    // ---- hold in WIN for three expiries, then RESET
    hold_pulse(); hold_pulse();
    @(negedge clk);
    check("win_hold", 32'(win), 1);
    timer_n = 1'b0;
    tick();
    timer_n = 1'b1;
    @(negedge clk);
    check("win_exit_clear", 32'(clear), 0);
    check("win_exit_win", 32'(win), 0);
    check("win_exit_points", 32'(points), 0);
    check("win_exit_level", 32'(level), 0);
    tick();
    @(negedge clk);
    check("win_restart", 32'(clear), 1);

    // ---- single-player collision, score frozen in LOSE
    start_game();
    coll = 2'b01;
    move_once(8'd1);
    coll = 2'b11;
    @(negedge clk);
    check("lose_loser", 32'(loser), 32'b10);
    check("lose_win", 32'(win), 0);
    hold_pulse();
    @(negedge clk);
    check("lose_frozen_pts", 32'(points), 1);
    check("lose_latched", 32'(loser), 32'b10);
    hold_pulse();
    timer_n = 1'b0;
    tick();
    timer_n = 1'b1;
    @(negedge clk);
    check("lose_exit_clear", 32'(clear), 0);
    check("lose_exit_loser", 32'(loser), 0);
    tick();

    // ---- simultaneous collision gives a draw
    start_game();
    coll = 2'b00;
    move_once(8'd1);
    coll = 2'b11;
    @(negedge clk);
    check("draw_loser", 32'(loser), 32'b11);
    hold_pulse(); hold_pulse(); hold_pulse();
    @(negedge clk);
    check("draw_exit_loser", 32'(loser), 0);
    tick();

    // ---- reset asserted during MOVE
    start_game();
    move_once(8'd1);
    sb.push_back(8'd0);
    timer_n = 1'b0;
    tick();
    timer_n = 1'b1;
    rst_n   = 1'b0;
    @(negedge clk);
    check("rstmove_in_move", 32'(move), 1);
    tick();
    @(negedge clk);
    check("rstmove_points", 32'(points), 0);
    check("rstmove_clear", 32'(clear), 0);
    check("rstmove_move", 32'(move), 0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rstmove_start", 32'(clear), 1);

    // ---- 4-player / 5-level instance
    rst4_n = 1'b1;
    tick();
    @(negedge clk);
    check("p4_start_tload", 32'(tload4), 12);
    check("p4_start_clear", 32'(clear4), 1);
    start4_n = 1'b0;
    tick();
    start4_n = 1'b1;
    ready4   = 4'b0111;
    tick();
    move4_once();
    @(negedge clk);
    check("p4_partial_ready", 32'(points4), 0);
    ready4 = 4'b0000;
    tick();
    ready4 = 4'hF;
    for (int p = 1; p <= 128; p++) begin
      move4_once();
      if (p % 32 == 0) begin
        @(negedge clk);
        check("p4_points", 32'(points4), 32'(p));
        check("p4_level", 32'(level4), 32'(p / 32));
        check("p4_tload", 32'(tload4), 32'(exp_load4[p / 32 - 1]));
      end
    end
    check("p4_no_win", 32'(win4), 0);
    check("p4_loser", 32'(loser4), 0);
    check("p4_move_idle", 32'(move4), 0);

    tick(); tick();
    check("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
